// File: rtl/score_uart_tx.sv
// score_uart_tx
// Waits for the packed-BCD high score from the SRAM bus listener to stop changing, then
// sends it as eight 8N1 UART bytes: six ASCII digits (most significant first), CR, LF.
// Digit nibbles above 9 are sent as '?'.
//
// Parameters:
//   CLKS_PER_BIT  - clk cycles per UART bit (>= 2)
//   SETTLE_CYCLES - consecutive unchanged cycles required before a value is sent (>= 1)
//
// Ports:
//   clk        - system clock
//   reset      - synchronous, active-high reset
//   score      - 24-bit packed BCD, [23:20] = 100k digit, [3:0] = units digit
//   tx         - UART serial output, idles high
//   busy       - high while a message is being shifted out
//   sent_count - completed messages, wraps 255 -> 0
module score_uart_tx #(
    parameter int unsigned CLKS_PER_BIT  = 104,
    parameter int unsigned SETTLE_CYCLES = 1200
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [23:0] score,
    output logic        tx,
    output logic        busy,
    output logic [7:0]  sent_count
);

    localparam int unsigned SettleW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam int unsigned BaudW   = $clog2(CLKS_PER_BIT);

    localparam logic [SettleW-1:0] SettleLast = SettleW'(SETTLE_CYCLES - 1);
    localparam logic [BaudW-1:0]   BaudLast   = BaudW'(CLKS_PER_BIT - 1);
    localparam logic [3:0]         StopBit    = 4'd9;
    localparam logic [2:0]         LastByte   = 3'd7;

    typedef enum logic [1:0] {
        StIdle,
        StSettle,
        StSend
    } state_e;

    state_e             state_q, state_d;
    logic [23:0]        last_sent_q, last_sent_d;
    logic [23:0]        candidate_q, candidate_d;
    logic [23:0]        shadow_q, shadow_d;
    logic [SettleW-1:0] settle_cnt_q, settle_cnt_d;
    logic [2:0]         byte_idx_q, byte_idx_d;
    logic [3:0]         bit_idx_q, bit_idx_d;
    logic [BaudW-1:0]   baud_cnt_q, baud_cnt_d;
    logic [7:0]         sent_count_q, sent_count_d;

    logic [7:0]         cur_byte;
    logic [3:0]         data_sel;

    function automatic logic [7:0] digit_ascii(input logic [3:0] nib);
        return (nib <= 4'd9) ? (8'h30 + {4'h0, nib}) : 8'h3F;
    endfunction

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StIdle;
            last_sent_q  <= 24'h0;
            candidate_q  <= 24'h0;
            shadow_q     <= 24'h0;
            settle_cnt_q <= '0;
            byte_idx_q   <= 3'd0;
            bit_idx_q    <= 4'd0;
            baud_cnt_q   <= '0;
            sent_count_q <= 8'd0;
        end else begin
            state_q      <= state_d;
            last_sent_q  <= last_sent_d;
            candidate_q  <= candidate_d;
            shadow_q     <= shadow_d;
            settle_cnt_q <= settle_cnt_d;
            byte_idx_q   <= byte_idx_d;
            bit_idx_q    <= bit_idx_d;
            baud_cnt_q   <= baud_cnt_d;
            sent_count_q <= sent_count_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d      = state_q;
        last_sent_d  = last_sent_q;
        candidate_d  = candidate_q;
        shadow_d     = shadow_q;
        settle_cnt_d = settle_cnt_q;
        byte_idx_d   = byte_idx_q;
        bit_idx_d    = bit_idx_q;
        baud_cnt_d   = baud_cnt_q;
        sent_count_d = sent_count_q;

        unique case (state_q)
            StIdle: begin
                if (score != last_sent_q) begin
                    candidate_d  = score;
                    settle_cnt_d = '0;
                    state_d      = StSettle;
                end
            end
            StSettle: begin
                // A change always wins, even on the cycle the counter would expire.
                if (score != candidate_q) begin
                    candidate_d  = score;
                    settle_cnt_d = '0;
                end else if (settle_cnt_q == SettleLast) begin
                    shadow_d    = candidate_q;
                    last_sent_d = candidate_q;
                    byte_idx_d  = 3'd0;
                    bit_idx_d   = 4'd0;
                    baud_cnt_d  = '0;
                    state_d     = StSend;
                end else begin
                    settle_cnt_d = settle_cnt_q + 1'b1;
                end
            end
            StSend: begin
                if (baud_cnt_q == BaudLast) begin
                    baud_cnt_d = '0;
                    if (bit_idx_q == StopBit) begin
                        bit_idx_d = 4'd0;
                        if (byte_idx_q == LastByte) begin
                            byte_idx_d   = 3'd0;
                            sent_count_d = sent_count_q + 8'd1;
                            state_d      = StIdle;
                        end else begin
                            byte_idx_d = byte_idx_q + 3'd1;
                        end
                    end else begin
                        bit_idx_d = bit_idx_q + 4'd1;
                    end
                end else begin
                    baud_cnt_d = baud_cnt_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Byte currently on the wire; shadow keeps it immune to score changes mid-message.
    always_comb begin
        cur_byte = 8'h0A;
        case (byte_idx_q)
            3'd0:    cur_byte = digit_ascii(shadow_q[23:20]);
            3'd1:    cur_byte = digit_ascii(shadow_q[19:16]);
            3'd2:    cur_byte = digit_ascii(shadow_q[15:12]);
            3'd3:    cur_byte = digit_ascii(shadow_q[11:8]);
            3'd4:    cur_byte = digit_ascii(shadow_q[7:4]);
            3'd5:    cur_byte = digit_ascii(shadow_q[3:0]);
            3'd6:    cur_byte = 8'h0D;
            default: cur_byte = 8'h0A;
        endcase
    end

    // Outputs: bit 0 is the start bit, bits 1..8 data LSB first, bit 9 the stop bit.
    always_comb begin
        tx         = 1'b1;
        busy       = 1'b0;
        data_sel   = bit_idx_q - 4'd1;
        sent_count = sent_count_q;
        if (state_q == StSend) begin
            busy = 1'b1;
            if (bit_idx_q == 4'd0) begin
                tx = 1'b0;
            end else if (bit_idx_q == StopBit) begin
                tx = 1'b1;
            end else begin
                tx = cur_byte[data_sel[2:0]];
            end
        end
    end

endmodule

// File: tb/tb_score_uart_tx.sv
module tb_score_uart_tx;

    localparam int CPB = 4;
    localparam int SC  = 8;
    localparam int MSG = 80 * CPB;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [23:0] score = 24'h0;
    logic        tx;
    logic        busy;
    logic [7:0]  sent_count;

    always #5 clk = ~clk;

    score_uart_tx #(
        .CLKS_PER_BIT (CPB),
        .SETTLE_CYCLES(SC)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .score     (score),
        .tx        (tx),
        .busy      (busy),
        .sent_count(sent_count)
    );

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    bit mon_flush = 1'b0;

    // Scoreboard: expected bytes and expected start cycle of each message (-1 = relative to
    // the previous message's end: first busy-low cycle + SC + 1).
    logic [7:0] exp_byte_q[$];
    int         exp_start_q[$];

    // Reference model state
    logic [23:0] m_last = 24'h0;
    bit          m_pend = 1'b0;

    always @(posedge clk) begin
        cyc++;
        if (reset) mon_flush = 1'b1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
        end
    endtask

    function automatic logic [7:0] ref_byte(input logic [23:0] v, input int i);
        int d;
        if (i == 6) return 8'h0D;
        if (i == 7) return 8'h0A;
        d = int'(v >> (20 - 4 * i)) & 15;
        if (d < 10) return 8'(48 + d);
        return 8'h3F;
    endfunction

    task automatic push_msg(input logic [23:0] v, input int start);
        for (int i = 0; i < 8; i++) exp_byte_q.push_back(ref_byte(v, i));
        exp_start_q.push_back(start);
    endtask

    // UART monitor: samples tx mid-bit on the falling clock edge.
    bit         in_frame = 1'b0;
    int         f_start = 0;
    logic [7:0] shreg = 8'h0;
    int         msg_byte = 0;
    int         busy_cnt = 0;
    bit         prev_busy = 1'b0;
    int         last_fall = 0;
    logic [7:0] m_done = 8'h0;
    int         frames_seen = 0;
    int         mon_s, mon_off, mon_j;

    always @(negedge clk) begin
        if (mon_flush) begin
            mon_flush = 1'b0;
            in_frame  = 1'b0;
            msg_byte  = 0;
            busy_cnt  = 0;
            prev_busy = busy;
            m_done    = 8'h0;
        end else begin
            if (busy) busy_cnt++;
            if (prev_busy && !busy) begin
                last_fall = cyc;
                m_done++;
                check("busy_width", busy_cnt, MSG);
                check("sent_count", sent_count, m_done);
                busy_cnt = 0;
            end
            if (!prev_busy && busy) check("tx_at_busy_rise", tx, 0);
            if (!busy && !in_frame) check("idle_tx", tx, 1);
            prev_busy = busy;

            if (!in_frame && tx === 1'b0) begin
                in_frame = 1'b1;
                f_start  = cyc;
                frames_seen++;
                if (msg_byte == 0) begin
                    checks++;
                    if (exp_start_q.size() == 0) begin
                        failures++;
                        $display("FAIL unexpected_start at cycle %0d: got start bit expected idle",
                                 cyc);
                    end else begin
                        checks--;
                        mon_s = exp_start_q.pop_front();
                        if (mon_s < 0) mon_s = last_fall + SC + 1;
                        check("start_cycle", cyc, mon_s);
                    end
                end
            end

            if (in_frame) begin
                mon_off = cyc - f_start;
                if (mon_off % CPB == CPB / 2) begin
                    mon_j = mon_off / CPB;
                    if (mon_j == 0) begin
                        check("start_bit", tx, 0);
                    end else if (mon_j <= 8) begin
                        shreg[mon_j-1] = tx;
                    end else begin
                        check("stop_bit", tx, 1);
                        in_frame = 1'b0;
                        if (exp_byte_q.size() == 0) begin
                            checks++;
                            failures++;
                            $display("FAIL unexpected_byte at cycle %0d: got 0x%0h expected none",
                                     cyc, shreg);
                        end else begin
                            check($sformatf("byte%0d", msg_byte), shreg, exp_byte_q.pop_front());
                        end
                        msg_byte = (msg_byte + 1) % 8;
                    end
                end
            end
        end
    end

    // Stimulus helpers; a value is sampled by the DUT in the cycle it is driven.
    task automatic set_score(input logic [23:0] v, output int t);
        @(negedge clk);
        score = v;
        t = cyc;
        if (v != m_last) m_pend = 1'b1;
    endtask

    task automatic hold_val(input logic [23:0] v, input int h);
        int t;
        set_score(v, t);
        repeat (h - 1) @(negedge clk);
    endtask

    // Once any value differing from the last sent one has appeared, the final stable value
    // is sent SC+1 cycles after it is first sampled.
    task automatic settle_to(input logic [23:0] v);
        int t;
        set_score(v, t);
        if (m_pend) push_msg(v, t + SC + 1);
        m_last = v;
        m_pend = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int n;
        n = 0;
        repeat (SC + 4) @(negedge clk);
        while (!(exp_byte_q.size() == 0 && busy == 1'b0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("drain_bytes", exp_byte_q.size(), 0);
    endtask

    task automatic wait_busy(output int f);
        int n;
        n = 0;
        while (busy !== 1'b1 && n < 4 * SC + 40) begin
            @(negedge clk);
            n++;
        end
        check("busy_rise_seen", busy, 1);
        f = cyc;
    endtask

    function automatic logic [23:0] rand_score();
        logic [23:0] v;
        for (int i = 0; i < 6; i++) begin
            if ($urandom_range(0, 3) == 0) v[4*i +: 4] = 4'($urandom_range(10, 15));
            else v[4*i +: 4] = 4'($urandom_range(0, 9));
        end
        return v;
    endfunction

    initial begin
        #500000;
        $display("FAIL global_timeout at cycle %0d: got no finish expected finish", cyc);
        $fatal(1);
    end

    initial begin
        int f, t, k, fr0;
        logic [23:0] v;

        // Reset values
        repeat (3) @(negedge clk);
        check("reset_tx", tx, 1);
        check("reset_busy", busy, 0);
        check("reset_count", sent_count, 0);
        reset = 1'b0;

        // Score 0 after reset is never sent
        fr0 = frames_seen;
        repeat (500) @(negedge clk);
        check("quiet_busy", busy, 0);
        check("quiet_count", sent_count, 0);
        check("quiet_frames", frames_seen - fr0, 0);

        settle_to(24'h030290);
        wait_done(2000);
        check("count_after_first", sent_count, 1);

        // Ripple writes: only the final value is sent
        hold_val(24'h000000, 3);
        hold_val(24'h100000, 3);
        hold_val(24'h120000, 3);
        settle_to(24'h123000);
        wait_done(2000);
        check("count_after_ripple", sent_count, 2);

        settle_to(24'h0A00F1);
        wait_done(2000);
        check("count_after_invalid", sent_count, 3);

        // Change during byte 2 is held back until the message ends
        settle_to(24'h000100);
        wait_busy(f);
        repeat (99) @(negedge clk);
        set_score(24'h000050, t);
        push_msg(24'h000050, -1);
        m_last = 24'h000050;
        m_pend = 1'b0;
        wait_done(3000);
        check("count_after_midsend", sent_count, 5);

        // Reset in the middle of byte 3
        settle_to(24'h000777);
        wait_busy(f);
        repeat (139) @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        exp_byte_q.delete();
        exp_start_q.delete();
        m_last = 24'h0;
        @(negedge clk);
        check("midreset_tx", tx, 1);
        check("midreset_busy", busy, 0);
        check("midreset_count", sent_count, 0);
        reset = 1'b0;
        push_msg(24'h000777, cyc + SC + 1);
        m_last = 24'h000777;
        wait_done(2000);
        check("count_after_reset", sent_count, 1);

        // Randomized ripples, holds up to exactly SC cycles, occasional repeats of last value
        for (int it = 0; it < 25; it++) begin
            k = $urandom_range(0, 3);
            for (int r = 0; r < k; r++) begin
                v = rand_score();
                if (v == score) v ^= 24'h1;
                hold_val(v, $urandom_range(1, SC));
            end
            if ($urandom_range(0, 3) == 0) v = m_last;
            else v = rand_score();
            if (k > 0 && v == score) v ^= 24'h1;
            settle_to(v);
            wait_done(3000);
            repeat ($urandom_range(0, 5)) @(negedge clk);
        end

        check("no_pending_msgs", exp_start_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
